bram_delay_prog: RTL and testbench

- Runtime-programmable BRAM delay line; successor to the fixed-DELAY BRAM delay.
- Delay is set at run time via a load strobe, up to 2^ADDR_BITS samples, and counts only ce-qualified cycles.
- Adds fill tracking, an output-valid flag, zeroed output while filling, and sticky out-of-range flagging.
- Sits in datapaths needing retunable alignment, e.g. per-antenna or beamformer delay compensation.

---
 rtl/bram_delay_pkg.sv | 28 ++
 rtl/sdp_bram.sv | 39 +++
 rtl/bram_delay_prog.sv | 112 +++++++++++
 tb/tb_bram_delay_prog.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/bram_delay_pkg.sv
// Shared constants, FSM encoding and delay clamp for the programmable BRAM delay line.
package bram_delay_pkg;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Smallest delay the read pipeline can honour: one sample must be written before it is read.
    function automatic int unsigned min_delay(input int unsigned latency);
        return latency + 32'd1;
    endfunction

    // Largest delay equals the BRAM depth.
    function automatic int unsigned max_delay(input int unsigned addr_bits);
        return 32'd1 << addr_bits;
    endfunction

    // Saturate a requested delay into [lo, hi].
    function automatic int unsigned clamp_delay(input int unsigned d,
                                                input int unsigned lo,
                                                input int unsigned hi);
        if (d < lo) return lo;
        if (d > hi) return hi;
        return d;
    endfunction

endpackage

// File: rtl/sdp_bram.sv
// Simple dual-port read-first BRAM with a ce-gated LATENCY-deep read pipeline.
module sdp_bram #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 ce,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_BITS;

    logic [WIDTH-1:0] mem  [DEPTH];
    logic [WIDTH-1:0] pipe [LATENCY];

    // Write port: one sample per accepted cycle.
    always_ff @(posedge clk) begin
        if (ce) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: stage 0 is the BRAM output register and sees pre-write contents (read-first).
    always_ff @(posedge clk) begin
        if (ce) begin
            pipe[0] <= mem[raddr];
            for (int i = 1; i < int'(LATENCY); i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign rdata = pipe[LATENCY-1];

endmodule

// File: rtl/bram_delay_prog.sv
// Runtime-programmable BRAM delay line with fill tracking, valid flag and sticky clamp error.
module bram_delay_prog
    import bram_delay_pkg::*;
#(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned ADDR_BITS     = 10,
    parameter int unsigned LATENCY       = 2,
    parameter int unsigned DEFAULT_DELAY = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic [WIDTH-1:0]     din,
    input  logic [ADDR_BITS:0]   delay_in,
    input  logic                 delay_ld,
    output logic [WIDTH-1:0]     dout,
    output logic                 dout_valid,
    output logic [ADDR_BITS:0]   delay_cur,
    output logic                 delay_err
);

    localparam int unsigned DW    = ADDR_BITS + 1;
    localparam int unsigned MIN_D = min_delay(LATENCY);
    localparam int unsigned MAX_D = max_delay(ADDR_BITS);

    state_t                state, state_nxt;
    logic [ADDR_BITS-1:0]  wptr;
    logic [DW-1:0]         fill_cnt, fill_nxt;
    logic [WIDTH-1:0]      dout_nxt;
    logic                  valid_nxt;
    logic [WIDTH-1:0]      rdata;
    logic [DW-1:0]         ld_val_c;
    logic                  ld_err_c;
    logic [DW-1:0]         d_eff_c;
    logic [ADDR_BITS-1:0]  raddr_c;

    // Clamp the requested delay and flag out-of-range loads.
    always_comb begin
        ld_val_c = DW'(clamp_delay(32'(delay_in), MIN_D, MAX_D));
        ld_err_c = (32'(delay_in) < MIN_D) || (32'(delay_in) > MAX_D);
    end

    // Read address leads the write pointer by LATENCY so the pipeline output lands D samples late;
    // a load in the same cycle takes effect on this read already.
    always_comb begin
        d_eff_c = delay_ld ? ld_val_c : delay_cur;
        raddr_c = ADDR_BITS'(wptr + ADDR_BITS'(LATENCY) - ADDR_BITS'(d_eff_c));
    end

    sdp_bram #(
        .WIDTH     (WIDTH),
        .ADDR_BITS (ADDR_BITS),
        .LATENCY   (LATENCY)
    ) u_bram (
        .clk   (clk),
        .ce    (ce),
        .waddr (wptr),
        .wdata (din),
        .raddr (raddr_c),
        .rdata (rdata)
    );

    // Next-state, fill counter and gated output data.
    always_comb begin
        state_nxt = state;
        fill_nxt  = fill_cnt;
        dout_nxt  = dout;
        valid_nxt = dout_valid;
        if (delay_ld) begin
            state_nxt = FILL;
            fill_nxt  = ce ? DW'(1) : '0;
            dout_nxt  = '0;
            valid_nxt = 1'b0;
        end else if (ce) begin
            if (state == FILL) begin
                if (fill_cnt >= delay_cur) begin
                    state_nxt = RUN;
                end else begin
                    fill_nxt = fill_cnt + DW'(1);
                end
            end
            valid_nxt = (state_nxt == RUN);
            dout_nxt  = valid_nxt ? rdata : '0;
        end
    end

    // State, pointer and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL;
            wptr       <= '0;
            fill_cnt   <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            delay_cur  <= DW'(DEFAULT_DELAY);
            delay_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            fill_cnt   <= fill_nxt;
            dout       <= dout_nxt;
            dout_valid <= valid_nxt;
            if (ce) begin
                wptr <= wptr + ADDR_BITS'(1);
            end
            if (delay_ld) begin
                delay_cur <= ld_val_c;
                delay_err <= delay_err | ld_err_c;
            end
        end
    end

endmodule

// File: tb/tb_bram_delay_prog.sv
// Scoreboard bench for bram_delay_prog: driver pushes expected outputs, monitor pops and compares.
module tb_bram_delay_prog;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned ADDR_BITS = 7;
    localparam int unsigned LATENCY   = 2;
    localparam int unsigned DEF_D     = 128;

    typedef struct packed {
        logic [31:0] dout;
        logic        valid;
        logic [7:0]  dcur;
        logic        err;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 ce;
    logic [WIDTH-1:0]     din;
    logic [ADDR_BITS:0]   delay_in;
    logic                 delay_ld;
    logic [WIDTH-1:0]     dout;
    logic                 dout_valid;
    logic [ADDR_BITS:0]   delay_cur;
    logic                 delay_err;

    bram_delay_prog #(
        .WIDTH         (WIDTH),
        .ADDR_BITS     (ADDR_BITS),
        .LATENCY       (LATENCY),
        .DEFAULT_DELAY (DEF_D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .din        (din),
        .delay_in   (delay_in),
        .delay_ld   (delay_ld),
        .dout       (dout),
        .dout_valid (dout_valid),
        .delay_cur  (delay_cur),
        .delay_err  (delay_err)
    );

    always #5 clk = ~clk;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] ctr = 0;
    logic [31:0] last_din = 0;

    // Reference model state (behavioural, indexed by accepted-sample number).
    logic [31:0] hist [4096];
    int          nacc = 0;
    logic        m_run = 1'b0;
    int          m_fill = 0;
    int          m_d = DEF_D;
    logic        m_err = 1'b0;
    logic [31:0] m_dout = 0;
    logic        m_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // One clock of stimulus; updates the model and queues the expected post-edge outputs.
    task automatic step(input logic r, input logic c, input logic l, input int dv);
        exp_t e;
        @(negedge clk);
        rst      = r;
        ce       = c;
        delay_ld = l;
        delay_in = 8'(dv);
        din      = ctr;
        last_din = ctr;
        if (r) begin
            m_run = 1'b0; m_fill = 0; m_d = DEF_D; m_err = 1'b0; m_dout = 0; m_valid = 1'b0;
        end else begin
            if (l) begin
                if (dv < 3) begin m_d = 3; m_err = 1'b1; end
                else if (dv > 128) begin m_d = 128; m_err = 1'b1; end
                else m_d = dv;
                m_run = 1'b0; m_fill = c ? 1 : 0; m_dout = 0; m_valid = 1'b0;
            end else if (c) begin
                if (!m_run) begin
                    if (m_fill >= m_d) m_run = 1'b1;
                    else m_fill++;
                end
                m_valid = m_run;
                m_dout  = m_run ? hist[nacc - m_d] : 32'd0;
            end
            if (c) begin
                hist[nacc] = ctr;
                nacc++;
            end
        end
        e.dout = m_dout; e.valid = m_valid; e.dcur = 8'(m_d); e.err = m_err;
        q.push_back(e);
        ctr++;
    endtask

    // Run ce=1 cycles until dout_valid rises (bounded); k = cycles taken, -1 if never.
    task automatic wait_valid(output int k);
        k = -1;
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b1, 1'b0, 0);
            @(posedge clk); #1;
            if (dout_valid) begin k = i; break; end
        end
    endtask

    // Monitor: compare every post-edge output against the queued expectation.
    always begin
        exp_t e;
        @(posedge clk); #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if (dout !== e.dout || dout_valid !== e.valid || delay_cur !== e.dcur || delay_err !== e.err) begin
                n_bad++;
                $display("FAIL sb t=%0t dout/valid/cur/err got %0d/%b/%0d/%b expected %0d/%b/%0d/%b",
                         $time, dout, dout_valid, delay_cur, delay_err, e.dout, e.valid, e.dcur, e.err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int k;
        rst = 1'b1; ce = 1'b0; din = '0; delay_in = '0; delay_ld = 1'b0;

        // Reset state
        repeat (3) step(1'b1, 1'b1, 1'b0, 0);
        @(posedge clk); #1;
        chk("rst_dout", dout, 0);
        chk("rst_valid", 32'(dout_valid), 0);
        chk("rst_cur", 32'(delay_cur), 128);
        chk("rst_err", 32'(delay_err), 0);

        // Scenario 1: default fill of 128 from ctr=0
        ctr = 0;
        wait_valid(k);
        chk("s1_fill_len", k, 128);
        chk("s1_first_dout", dout, 0);
        repeat (20) step(1'b0, 1'b1, 1'b0, 0);

        // Scenario 2: retune to 10 while running
        step(1'b0, 1'b1, 1'b1, 10);
        @(posedge clk); #1;
        chk("s2_cur", 32'(delay_cur), 10);
        chk("s2_err", 32'(delay_err), 0);
        chk("s2_valid_drop", 32'(dout_valid), 0);
        wait_valid(k);
        chk("s2_fill_len", k, 9);
        chk("s2_dout", dout, last_din - 10);
        repeat (20) step(1'b0, 1'b1, 1'b0, 0);

        // Scenario 3: clamp low then high; error is sticky
        step(1'b0, 1'b1, 1'b1, 1);
        @(posedge clk); #1;
        chk("s3_cur_lo", 32'(delay_cur), 3);
        chk("s3_err_lo", 32'(delay_err), 1);
        repeat (10) step(1'b0, 1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 1'b1, 200);
        @(posedge clk); #1;
        chk("s3_cur_hi", 32'(delay_cur), 128);
        chk("s3_err_hi", 32'(delay_err), 1);
        wait_valid(k);
        chk("s3_fill_len", k, 127);
        chk("s3_dout", dout, last_din - 128);
        repeat (10) step(1'b0, 1'b1, 1'b0, 0);

        // Scenario 4: D=5 with ce toggling, including a load while ce=0
        step(1'b0, 1'b1, 1'b1, 5);
        for (int i = 0; i < 40; i++) step(1'b0, ((i % 3) != 2), 1'b0, 0);
        step(1'b0, 1'b0, 1'b1, 5);
        for (int i = 0; i < 40; i++) step(1'b0, i[0], 1'b0, 0);

        // Scenario 5: reset together with a load mid-run; full refill follows
        step(1'b1, 1'b1, 1'b1, 10);
        @(posedge clk); #1;
        chk("s5_dout", dout, 0);
        chk("s5_valid", 32'(dout_valid), 0);
        chk("s5_cur", 32'(delay_cur), 128);
        chk("s5_err", 32'(delay_err), 0);
        wait_valid(k);
        chk("s5_fill_len", k, 128);
        chk("s5_dout_valid", dout, last_din - 128);

        // Scenario 6: minimum delay across several pointer wraps
        step(1'b0, 1'b1, 1'b1, 3);
        wait_valid(k);
        chk("s6_fill_len", k, 2);
        chk("s6_dout", dout, last_din - 3);
        repeat (300) step(1'b0, 1'b1, 1'b0, 0);

        // Drain the scoreboard
        @(posedge clk); #2;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
